// File: rtl/mem_ctrl.sv
// Single-port RAM arbiter: MEM byte requests pass straight through with absolute
// priority; IF word fetches are assembled from four little-endian byte reads and
// restarted from byte 0 whenever MEM takes the port mid-fetch.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch side
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic [31:0]       if_inst,
  output logic              if_done,
  // MEM stage side
  input  logic [1:0]        mem_request,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_ctrl_data_o,
  output logic [7:0]        mem_ctrl_data_i,
  // port owner: 01 IF, 10 MEM, 00 idle
  output logic [1:0]        if_or_mem,
  // RAM side
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       inst_q, inst_d;
  logic              done_q, done_d;

  logic              mem_active;
  logic [ADDR_W-1:0] fetch_off;

  // 11 on mem_request is treated as no request for port ownership.
  assign mem_active = (mem_request == 2'b01) || (mem_request == 2'b10);

  // Byte offset saturates at 3: cnt=4 only consumes the byte presented at cnt=3.
  assign fetch_off = (cnt_q >= 3'd3) ? ADDR_W'(3) : ADDR_W'(cnt_q);

  // Read data always flows back to MEM unbuffered.
  assign mem_ctrl_data_i = ram_din;
  assign if_inst         = inst_q;
  assign if_done         = done_q & ~if_flush;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      pc_q    <= '0;
      word_q  <= 32'd0;
      inst_q  <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
    end
  end

  // IF fetch FSM: next state, byte capture and word completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    word_d  = word_q;
    inst_d  = inst_q;
    done_d  = 1'b0;

    if (if_flush) begin
      // Flush beats everything, including a simultaneous request.
      state_d = StIdle;
      cnt_d   = 3'd0;
      word_d  = 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_request && !mem_active) begin
            pc_d    = if_pc;
            state_d = StFetch;
            cnt_d   = 3'd0;
          end
        end
        StFetch: begin
          if (mem_active) begin
            // Preempted: drop partial bytes, restart from byte 0 later.
            state_d = StHold;
            cnt_d   = 3'd0;
            word_d  = 32'd0;
          end else if (cnt_q == 3'd4) begin
            inst_d  = {ram_din, word_q[23:0]};
            done_d  = 1'b1;
            state_d = StIdle;
            cnt_d   = 3'd0;
            word_d  = 32'd0;
          end else begin
            // ram_din holds the byte addressed in the previous cycle.
            case (cnt_q)
              3'd1:    word_d[7:0]   = ram_din;
              3'd2:    word_d[15:8]  = ram_din;
              3'd3:    word_d[23:16] = ram_din;
              default: ;
            endcase
            cnt_d = cnt_q + 3'd1;
          end
        end
        StHold: begin
          if (mem_request == 2'b00) begin
            state_d = StFetch;
            cnt_d   = 3'd0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // RAM port mux: MEM wins combinationally, then an active fetch, else idle.
  always_comb begin
    ram_a     = pc_q;
    ram_wr    = 1'b0;
    ram_dout  = 8'd0;
    if_or_mem = 2'b00;
    if (mem_active) begin
      ram_a     = mem_addr;
      ram_dout  = mem_ctrl_data_o;
      ram_wr    = (mem_request == 2'b10);
      if_or_mem = 2'b10;
    end else if (state_q == StFetch) begin
      ram_a     = pc_q + fetch_off;
      if_or_mem = 2'b01;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, IF word scoreboard, directed MEM,
// preemption, flush and reset scenarios.
module tb_mem_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              if_request;
  logic [ADDR_W-1:0] if_pc;
  logic              if_flush;
  logic [31:0]       if_inst;
  logic              if_done;
  logic [1:0]        mem_request;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_ctrl_data_o;
  logic [7:0]        mem_ctrl_data_i;
  logic [1:0]        if_or_mem;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  logic [31:0] exp_q[$];

  // 1 KiB RAM; low address bits keep all test addresses distinct, incl. wrap.
  logic [7:0] ram [1024];

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_request      (if_request),
    .if_pc           (if_pc),
    .if_flush        (if_flush),
    .if_inst         (if_inst),
    .if_done         (if_done),
    .mem_request     (mem_request),
    .mem_addr        (mem_addr),
    .mem_ctrl_data_o (mem_ctrl_data_o),
    .mem_ctrl_data_i (mem_ctrl_data_i),
    .if_or_mem       (if_or_mem),
    .ram_a           (ram_a),
    .ram_wr          (ram_wr),
    .ram_dout        (ram_dout),
    .ram_din         (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: contents loaded while reset is low; read data lags address by one cycle.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h13;
      ram[10'h101] <= 8'h05;
      ram[10'h102] <= 8'h00;
      ram[10'h103] <= 8'h00;
      ram[10'h200] <= 8'hA5;
      ram[10'h3FE] <= 8'h11;
      ram[10'h3FF] <= 8'h22;
      ram[10'h000] <= 8'h33;
      ram[10'h001] <= 8'h44;
      ram_din      <= 8'h00;
    end else begin
      ram_din <= ram[ram_a[9:0]];
      if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for if_done with a cycle budget; the number of edges taken is the result.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!if_done && n < 20) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_cycles));
  endtask

  // Scoreboard: every done pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && if_done) begin
      done_seen++;
      if (exp_q.size() == 0) check_eq("spurious_done", 32'(if_done), 32'd0);
      else check_eq("sb_inst", if_inst, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int saved;
    rst             = 1'b1;
    if_request      = 1'b0;
    if_pc           = '0;
    if_flush        = 1'b0;
    mem_request     = 2'b00;
    mem_addr        = '0;
    mem_ctrl_data_o = 8'h00;

    #2 rst = 1'b0;
    #1;
    check_eq("rst_inst", if_inst, 32'd0);
    check_eq("rst_done", 32'(if_done), 32'd0);
    check_eq("rst_ram_a", ram_a, 32'd0);
    check_eq("rst_owner", 32'(if_or_mem), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Plain fetch at 0x100.
    if_request = 1'b1;
    if_pc      = 32'h100;
    exp_q.push_back(32'h0000_0513);
    step();
    if_request = 1'b0;
    #1;
    check_eq("fetch_addr0", ram_a, 32'h100);
    for (int i = 0; i < 5; i++) begin
      check_eq("fetch_owner", 32'(if_or_mem), 32'h1);
      check_eq("fetch_no_early_done", 32'(if_done), 32'd0);
      if (i == 1) check_eq("fetch_addr1", ram_a, 32'h101);
      step();
    end
    check_eq("fetch_done", 32'(if_done), 32'd1);
    check_eq("fetch_owner_idle", 32'(if_or_mem), 32'd0);
    step();
    check_eq("done_pulse", 32'(if_done), 32'd0);
    check_eq("inst_hold", if_inst, 32'h0000_0513);

    // MEM load.
    mem_request = 2'b01;
    mem_addr    = 32'h200;
    #1;
    check_eq("load_ram_a", ram_a, 32'h200);
    check_eq("load_owner", 32'(if_or_mem), 32'h2);
    check_eq("load_wr", 32'(ram_wr), 32'd0);
    step();
    mem_request = 2'b00;
    #1;
    check_eq("load_data", 32'(mem_ctrl_data_i), 32'hA5);

    // MEM store then read back.
    mem_request     = 2'b10;
    mem_addr        = 32'h300;
    mem_ctrl_data_o = 8'h5A;
    #1;
    check_eq("store_wr", 32'(ram_wr), 32'd1);
    check_eq("store_dout", 32'(ram_dout), 32'h5A);
    step();
    mem_request = 2'b01;
    step();
    mem_request = 2'b00;
    #1;
    check_eq("store_readback", 32'(mem_ctrl_data_i), 32'h5A);

    // Preemption at cnt=2 by a 4-cycle load.
    if_request = 1'b1;
    if_pc      = 32'h100;
    exp_q.push_back(32'h0000_0513);
    step();
    if_request = 1'b0;
    step();
    step();
    mem_request = 2'b01;
    mem_addr    = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("preempt_owner", 32'(if_or_mem), 32'h2);
      check_eq("preempt_no_done", 32'(if_done), 32'd0);
      step();
    end
    mem_request = 2'b00;
    #1;
    check_eq("hold_idle_port", 32'(if_or_mem), 32'd0);
    wait_done("preempt_latency", 6);
    step();

    // Flush at cnt=3.
    saved      = done_seen;
    if_request = 1'b1;
    if_pc      = 32'h100;
    step();
    if_request = 1'b0;
    step();
    step();
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    #1;
    check_eq("flush_idle", 32'(if_or_mem), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check_eq("flush_no_done", 32'(done_seen), 32'(saved));

    // Flush in the done cycle masks if_done.
    saved      = done_seen;
    if_request = 1'b1;
    if_pc      = 32'h100;
    step();
    if_request = 1'b0;
    for (int i = 0; i < 5; i++) step();
    if_flush = 1'b1;
    #1;
    check_eq("flush_done_mask", 32'(if_done), 32'd0);
    step();
    if_flush = 1'b0;
    step();
    check_eq("flush_mask_no_done", 32'(done_seen), 32'(saved));

    // Reset mid-fetch, then a wrapping fetch.
    saved      = done_seen;
    if_request = 1'b1;
    if_pc      = 32'h100;
    step();
    if_request = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("midrst_inst", if_inst, 32'd0);
    check_eq("midrst_done", 32'(if_done), 32'd0);
    check_eq("midrst_ram_a", ram_a, 32'd0);
    check_eq("midrst_owner", 32'(if_or_mem), 32'd0);
    check_eq("midrst_wr", 32'(ram_wr), 32'd0);
    step();
    rst = 1'b1;
    step();
    check_eq("postrst_idle", 32'(if_or_mem), 32'd0);
    if_request = 1'b1;
    if_pc      = 32'hFFFF_FFFE;
    exp_q.push_back(32'h4433_2211);
    step();
    if_request = 1'b0;
    wait_done("wrap_latency", 5);
    step();
    check_eq("postrst_done_count", 32'(done_seen), 32'(saved + 1));
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory arbiter between instruction fetch and the MEM stage, sitting directly below the `mem` stage and the IF stage and directly above the byte-wide RAM. MEM's byte-serial LOAD/STORE requests are passed straight to the RAM with absolute priority. IF asks for a full 32-bit word; this block fetches it as four little-endian bytes, then returns it with a done pulse. An IF fetch is abandoned and restarted whenever MEM takes the port.

## Interface
Parameters:
- `ADDR_W`, 32: address width of the IF, MEM and RAM ports.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_request` in 1: IF wants a word at `if_pc`; sampled only in IDLE.
- `if_pc` in ADDR_W: byte address of the instruction word.
- `if_flush` in 1: abort any IF fetch (branch redirect).
- `if_inst` out 32: assembled instruction word.
- `if_done` out 1: one-cycle pulse; `if_inst` valid.
- `mem_request` in 2: 00 none, 01 LOAD byte, 10 STORE byte, 11 treated as none.
- `mem_addr` in ADDR_W: MEM byte address.
- `mem_ctrl_data_o` in 8: MEM store byte.
- `mem_ctrl_data_i` out 8: read byte returned to MEM (= `ram_din`).
- `if_or_mem` out 2: current port owner. 01 IF, 10 MEM, 00 idle.
- `ram_a` out ADDR_W: RAM address.
- `ram_wr` out 1: RAM write enable.
- `ram_dout` out 8: RAM write data.
- `ram_din` in 8: RAM read data. It is the byte at the address presented in the previous cycle.

## Operation
- **MEM path (combinational):**
  - Whenever `mem_request` is 01 or 10: `ram_a`=`mem_addr`, `ram_dout`=`mem_ctrl_data_o`, `ram_wr`=(`mem_request`==10), `if_or_mem`=10.
  - `mem_ctrl_data_i`=`ram_din` at all times.
  - No buffering on this path. MEM sees its byte one cycle after presenting the address.
- **IF FSM states:** IDLE, FETCH (counter `cnt` 0..4), HOLD.
- **IDLE:**
  - `if_request`=1, `if_flush`=0 and no MEM request: latch `if_pc` into `pc_q`, go to FETCH with `cnt`=0.
  - `if_request` with MEM active: stay in IDLE; the request is re-sampled each cycle.
- **FETCH, no MEM request:**
  - Drive `ram_a`=`pc_q`+min(`cnt`,3), `ram_wr`=0, `if_or_mem`=01.
  - At each edge with `cnt`≥1, capture `ram_din` into byte `cnt`-1 of the word buffer. Byte 0 goes to [7:0], byte 3 to [31:24].
  - `cnt`=4 edge: load `if_inst` with the full word, set `if_done`=1 for one cycle, return to IDLE.
- **FETCH with MEM request:** go to HOLD and discard the partial bytes. Any byte captured this cycle is dropped.
- **HOLD:**
  - While `mem_request`≠00, stay in HOLD.
  - When `mem_request`=00, go to FETCH with `cnt`=0 using the retained `pc_q`. IF need not re-request.
- **`if_flush`=1 (any state):** next state IDLE, partial word discarded. `if_done` output is `if_done_q & ~if_flush`.
- **Simultaneous flush and request:** flush wins; the request is not latched.
- **Address arithmetic:** `pc_q`+k wraps modulo 2^ADDR_W. No alignment is required.
- **Idle port:** when neither side owns it, `ram_a` holds `pc_q`, `ram_wr`=0, `if_or_mem`=00.

## Timing
- **Reset:** `rst` low asynchronously forces:
  - state IDLE, `cnt`=0, `pc_q`=0, word buffer 0;
  - outputs `if_inst`=0, `if_done`=0, `ram_a`=0, `ram_wr`=0, `ram_dout`=0, `if_or_mem`=00.
  - Reset mid-fetch drops the fetch. The first edge after release evaluates IDLE.
- **IF latency** (with `if_request` sampled at edge E0):
  - E1 presents `pc`+1, and `cnt`=1 is the first capture state. Bytes are captured at E2..E5.
  - `if_done` is high in the cycle after E5: 5 cycles from the request edge, 6 edges of occupancy.
- **`if_done`:** exactly one cycle. `if_inst` holds its value until the next done.
- **MEM priority:** effective in the same cycle `mem_request` becomes nonzero. IF restart costs 5 further cycles after MEM releases.
- **MEM's last cycle:** the final request cycle may re-present an address; this is harmless because it is a read or a repeated write of the same byte.

## Test plan
- **Plain fetch:** RAM[0x100..0x103]=13,05,00,00; `if_request` with pc=0x100, no MEM activity. Required: `if_done` 5 cycles later, `if_inst`=0x00000513, `if_or_mem`=01 throughout the fetch.
- **MEM load:** `mem_request`=01 at 0x200 (RAM=0xA5). Required: `ram_a`=0x200 the same cycle, `mem_ctrl_data_i`=0xA5 the next cycle, `if_or_mem`=10, `ram_wr`=0.
- **MEM store:** `mem_request`=10, addr 0x300, data 0x5A. Required: `ram_wr`=1 that cycle; a following load of 0x300 returns 0x5A.
- **Preemption:** start a fetch at 0x100, then assert a 4-cycle MEM LOAD at fetch `cnt`=2. Required: HOLD during MEM, restart at `cnt`=0, `if_done` 5 cycles after MEM releases, correct word 0x00000513, no early `if_done`.
- **Flush:**
  - Assert `if_flush` at `cnt`=3: no `if_done`, FSM back in IDLE.
  - Assert `if_flush` in the `if_done` cycle: `if_done` output reads 0.
- **Reset:** drive `rst` low mid-fetch for 1 cycle. Required: all outputs at reset values immediately, no `if_done`, then a new fetch at 0xFFFFFFFE wraps and returns bytes from FFFFFFFE, FFFFFFFF, 0, 1.
